// File: rtl/serial_code_pkg.sv
// rtl/serial_code_pkg.sv - shared types and sizing helpers for the serial code loader
//
// Purpose : loader FSM state encoding and bit-counter width helpers.
// Ports   : none (package).
package serial_code_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } loader_state_t;

  localparam int WIDTH_DEF   = 6;
  localparam int SYNC_FF_DEF = 2;
  localparam int CNT_W       = $clog2(WIDTH_DEF + 1);

  // Counter width able to hold the values 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// rtl/btn_edge_sync.sv - synchroniser plus rising-edge pulse for one raw button
//
// Purpose : brings an asynchronous button into the clk domain and emits a
//           single-cycle pulse per rising edge. A held button gives one pulse.
// Ports   : clk   in  system clock
//           rst   in  asynchronous active-low reset
//           raw   in  raw asynchronous button level
//           pulse out one-cycle registered pulse, SYNC_FF+1 clocks after raw rises
module btn_edge_sync #(
  parameter int SYNC_FF = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  logic [SYNC_FF-1:0] sync_q;
  logic               hist_q;
  logic               pulse_q;

  // The edge pulse is registered so the consuming FSM only ever sees a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      hist_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_FF-2:0], raw};
      hist_q  <= sync_q[SYNC_FF-1];
      pulse_q <= sync_q[SYNC_FF-1] & ~hist_q;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/serial_code_loader.sv
// rtl/serial_code_loader.sv - assembles a WIDTH-bit code from button presses and strobes it out
//
// Purpose : each btn0/btn1 rising edge shifts a '0'/'1' into a code register;
//           after WIDTH bits the code is presented on d with a one-cycle load.
// Ports   : clk      in   system clock
//           rst      in   asynchronous active-low reset
//           btn0     in   raw button, enters bit '0'
//           btn1     in   raw button, enters bit '1'
//           btn_clr  in   raw button, aborts the partial entry
//           d        out  last completed code (never a partial code)
//           load     out  one-cycle registered strobe, d stable while high
//           busy     out  partial code held
//           bit_cnt  out  bits accepted so far
module serial_code_loader
  import serial_code_pkg::*;
#(
  parameter int WIDTH   = 6,
  parameter int SYNC_FF = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       btn0,
  input  logic                       btn1,
  input  logic                       btn_clr,
  output logic [WIDTH-1:0]           d,
  output logic                       load,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

  localparam int CW = cnt_width(WIDTH);

  logic p0, p1, p_clr;

  btn_edge_sync #(.SYNC_FF(SYNC_FF)) u_sync_b0  (.clk(clk), .rst(rst), .raw(btn0),    .pulse(p0));
  btn_edge_sync #(.SYNC_FF(SYNC_FF)) u_sync_b1  (.clk(clk), .rst(rst), .raw(btn1),    .pulse(p1));
  btn_edge_sync #(.SYNC_FF(SYNC_FF)) u_sync_clr (.clk(clk), .rst(rst), .raw(btn_clr), .pulse(p_clr));

  loader_state_t     state_q, state_d;
  logic [WIDTH-1:0]  shreg_q, shreg_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              load_q, load_d;

  // Simultaneous 0 and 1 presses are ambiguous and dropped together.
  logic             accept;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt_inc;

  assign accept  = (p0 ^ p1) & ~p_clr;
  assign shifted = {shreg_q[WIDTH-2:0], p1};
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    load_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (p_clr) begin
          shreg_d = '0;
          cnt_d   = '0;
        end else if (accept) begin
          shreg_d = shifted;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (p_clr) begin
          shreg_d = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (accept) begin
          shreg_d = shifted;
          cnt_d   = cnt_inc;
          if (cnt_inc == CW'(WIDTH)) begin
            // d is updated on the same edge that raises load.
            d_d     = shifted;
            load_d  = 1'b1;
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        shreg_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        shreg_d = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
    end
  end

  assign d       = d_q;
  assign load    = load_q;
  assign busy    = (state_q == SHIFT);
  assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_serial_code_loader.sv
// tb/tb_serial_code_loader.sv - directed self-checking bench for serial_code_loader
module tb_serial_code_loader;

  localparam int WIDTH   = 6;
  localparam int SYNC_FF = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             btn0 = 1'b0;
  logic             btn1 = 1'b0;
  logic             btn_clr = 1'b0;
  logic [WIDTH-1:0] d;
  logic             load;
  logic             busy;
  logic [2:0]       bit_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int load_cnt = 0;
  int press_cyc = 0;
  int load_cyc  = 0;

  serial_code_loader #(.WIDTH(WIDTH), .SYNC_FF(SYNC_FF)) dut (
    .clk(clk), .rst(rst), .btn0(btn0), .btn1(btn1), .btn_clr(btn_clr),
    .d(d), .load(load), .busy(busy), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (load) begin
      load_cnt = load_cnt + 1;
      load_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // which: 0 = btn0, 1 = btn1, 2 = btn_clr, 3 = btn0 and btn1 together
  task automatic press(input int which);
    @(posedge clk);
    #1;
    press_cyc = cyc;
    if (which == 0 || which == 3) btn0 = 1'b1;
    if (which == 1 || which == 3) btn1 = 1'b1;
    if (which == 2) btn_clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    btn0 = 1'b0;
    btn1 = 1'b0;
    btn_clr = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic enter(input logic [WIDTH-1:0] code);
    for (int i = WIDTH - 1; i >= 0; i--) press(code[i] ? 1 : 0);
  endtask

  initial begin
    // 1: reset held with buttons toggling
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      btn0 = ~btn0;
      btn1 = (i % 2 == 0);
      btn_clr = ~btn_clr;
      @(negedge clk);
      check("rst_d", 32'(d), 32'h0);
      check("rst_load", 32'(load), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_cnt", 32'(bit_cnt), 32'h0);
    end
    btn0 = 1'b0; btn1 = 1'b0; btn_clr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_cnt", 32'(bit_cnt), 32'h0);

    // 2: clean entry 101101
    load_cnt = 0;
    press(1);
    check("t2_busy_first", 32'(busy), 32'h1);
    check("t2_cnt_first", 32'(bit_cnt), 32'h1);
    press(0); press(1); press(1); press(0);
    check("t2_cnt_five", 32'(bit_cnt), 32'h5);
    check("t2_no_early_load", 32'(load_cnt), 32'h0);
    press(1);
    check("t2_load_cnt", 32'(load_cnt), 32'h1);
    check("t2_d", 32'(d), 32'h2d);
    check("t2_latency", 32'(load_cyc - press_cyc), 32'(SYNC_FF + 2));
    check("t2_busy_after", 32'(busy), 32'h0);
    check("t2_cnt_after", 32'(bit_cnt), 32'h0);

    // 3: abort with clear, then 000001
    load_cnt = 0;
    press(1); press(1); press(1);
    check("t3_cnt_three", 32'(bit_cnt), 32'h3);
    press(2);
    check("t3_clr_cnt", 32'(bit_cnt), 32'h0);
    check("t3_clr_busy", 32'(busy), 32'h0);
    check("t3_clr_noload", 32'(load_cnt), 32'h0);
    check("t3_clr_d_kept", 32'(d), 32'h2d);
    enter(6'b000001);
    check("t3_load_cnt", 32'(load_cnt), 32'h1);
    check("t3_d", 32'(d), 32'h01);

    // 4: simultaneous 0/1 is discarded
    load_cnt = 0;
    press(1); press(0);
    check("t4_cnt_two", 32'(bit_cnt), 32'h2);
    press(3);
    check("t4_dual_cnt", 32'(bit_cnt), 32'h2);
    press(1); press(1); press(1); press(1);
    check("t4_load_cnt", 32'(load_cnt), 32'h1);
    check("t4_d", 32'(d), 32'h2f);

    // 5: held button yields one bit
    @(posedge clk);
    #1;
    btn1 = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    check("t5_held_cnt", 32'(bit_cnt), 32'h1);
    btn1 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("t5_release_cnt", 32'(bit_cnt), 32'h1);
    press(2);
    check("t5_clr_cnt", 32'(bit_cnt), 32'h0);

    // 6: reset mid-entry, then 010101
    press(0); press(1); press(1); press(0);
    check("t6_cnt_four", 32'(bit_cnt), 32'h4);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("t6_async_busy", 32'(busy), 32'h0);
    check("t6_async_cnt", 32'(bit_cnt), 32'h0);
    check("t6_async_d", 32'(d), 32'h0);
    check("t6_async_load", 32'(load), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    load_cnt = 0;
    enter(6'b010101);
    check("t6_load_cnt", 32'(load_cnt), 32'h1);
    check("t6_d", 32'(d), 32'h15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
